// File: rtl/data_sram_resp.sv
// data_sram_resp
//   Memory-end responder for the EX-stage data_sram request bus. Performs
//   byte-masked word writes and registered word reads; read data returns to
//   the MEM stage one cycle after the access edge.
//
//   Optional feature macro: DATA_SRAM_WAIT_EN
//     defined   -> IDLE/WAIT/ACCESS wait-state engine, WAIT_CYCLES wait
//                  states per access, stall_for_mem requests a pipeline stall
//     undefined -> every request is accessed in its presentation cycle,
//                  stall_for_mem tied 0, WAIT_CYCLES ignored
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     data_sram_en      access request
//     data_sram_wen     byte write enables (0000 with en=1 is a read)
//     data_sram_addr    byte address
//     data_sram_wdata   write data, lanes pre-replicated by the initiator
//     data_sram_rdata   read data word (holds until the next read response)
//     resp_valid        one-cycle pulse, rdata valid this cycle
//     addr_err          one-cycle pulse for an out-of-range access
//     stall_for_mem     stall request to the pipeline stall controller
//
//   State table (wait-state build only)
//     state  | meaning
//     IDLE   | accepting; a request with WAIT_CYCLES>0 is latched here
//     WAIT   | stalling, counting down the remaining wait states
//     ACCESS | latched request hits the array at this cycle's edge
module data_sram_resp #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        addr_err,
  output logic        stall_for_mem
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic        resp_valid_q;
  logic        addr_err_q;

  // Access that hits the array at the coming edge
  logic        acc_go;
  logic [3:0]  acc_wen;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

`ifdef DATA_SRAM_WAIT_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  // IDLE already counts as the first wait state, so WAIT holds for
  // WAIT_CYCLES-1 cycles before ACCESS.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  req_wen_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic        latch_req;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    latch_req     = 1'b0;
    stall_for_mem = 1'b0;
    acc_go        = 1'b0;
    acc_wen       = data_sram_wen;
    acc_addr      = data_sram_addr;
    acc_wdata     = data_sram_wdata;
    case (state_q)
      S_IDLE: begin
        if (data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            acc_go = 1'b1;
          end else begin
            latch_req     = 1'b1;
            stall_for_mem = 1'b1;
            cnt_d         = CNT_LOAD;
            state_d       = (CNT_LOAD == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_for_mem = 1'b1;
        cnt_d         = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        acc_go    = 1'b1;
        acc_wen   = req_wen_q;
        acc_addr  = req_addr_q;
        acc_wdata = req_wdata_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_req) begin
      req_wen_q   <= data_sram_wen;
      req_addr_q  <= data_sram_addr;
      req_wdata_q <= data_sram_wdata;
    end
  end
`else
  always_comb begin
    acc_go        = data_sram_en;
    acc_wen       = data_sram_wen;
    acc_addr      = data_sram_addr;
    acc_wdata     = data_sram_wdata;
    stall_for_mem = 1'b0;
  end
`endif

  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              is_read;
  logic              unused_addr_lsb;

  assign in_range        = (acc_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign idx             = acc_addr[ADDR_W+1:2];
  assign is_read         = (acc_wen == 4'b0000);
  // Byte offset never selects lanes; wen does.
  assign unused_addr_lsb = ^acc_addr[1:0];

  // Gated by rst so a write pending in ACCESS is dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst && acc_go && !is_read && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem_q[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= acc_go && is_read;
      addr_err_q   <= acc_go && !in_range;
      if (acc_go && is_read) begin
        rdata_q <= in_range ? mem_q[idx] : 32'd0;
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign resp_valid      = resp_valid_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp. The main instance runs with zero wait
// states (identical timing in both builds); with DATA_SRAM_WAIT_EN defined,
// two extra instances exercise 2 and 3 wait states.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;
  logic        err;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst),
    .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata), .resp_valid(valid),
    .addr_err(err), .stall_for_mem(stall)
  );

`ifdef DATA_SRAM_WAIT_EN
  logic        en2, en3;
  logic [3:0]  wen2, wen3;
  logic [31:0] addr2, addr3, wdata2, wdata3, rdata2, rdata3;
  logic        valid2, valid3, err2, err3, stall2, stall3;

  data_sram_resp #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst),
    .data_sram_en(en2), .data_sram_wen(wen2), .data_sram_addr(addr2),
    .data_sram_wdata(wdata2), .data_sram_rdata(rdata2), .resp_valid(valid2),
    .addr_err(err2), .stall_for_mem(stall2)
  );

  data_sram_resp #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst),
    .data_sram_en(en3), .data_sram_wen(wen3), .data_sram_addr(addr3),
    .data_sram_wdata(wdata3), .data_sram_rdata(rdata3), .resp_valid(valid3),
    .addr_err(err3), .stall_for_mem(stall3)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    req(1'b0, 4'h0, 32'h0, 32'h0);
`ifdef DATA_SRAM_WAIT_EN
    en2 = 1'b0; wen2 = 4'h0; addr2 = 32'h0; wdata2 = 32'h0;
    en3 = 1'b0; wen3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
`endif
    tick(); tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Full-word write then read
    req(1'b1, 4'hF, 32'h10, 32'h1234_5678); tick();
    check("wr_valid", {31'd0, valid}, 32'd0);
    check("wr_err",   {31'd0, err},   32'd0);
    req(1'b1, 4'h0, 32'h10, 32'h0); tick();
    check("rd10_data",  rdata, 32'h1234_5678);
    check("rd10_valid", {31'd0, valid}, 32'd1);
    check("rd10_err",   {31'd0, err},   32'd0);

    // Byte / half lanes
    req(1'b1, 4'hF, 32'h20, 32'hAABB_CCDD); tick();
    req(1'b1, 4'b0010, 32'h20, 32'h1111_1111); tick();
    req(1'b1, 4'b1100, 32'h20, 32'h2233_2233); tick();
    req(1'b1, 4'h0, 32'h20, 32'h0); tick();
    check("lanes_data", rdata, 32'h2233_11DD);

    // Out of range
    req(1'b1, 4'hF, 32'h0, 32'h0BAD_F00D); tick();
    req(1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF); tick();
    check("oor_wr_err",   {31'd0, err},   32'd1);
    check("oor_wr_valid", {31'd0, valid}, 32'd0);
    check("oor_wr_rdata", rdata, 32'h2233_11DD);
    req(1'b1, 4'h0, 32'h0000_1000, 32'h0); tick();
    check("oor_rd_data", rdata, 32'h0);
    check("oor_rd_err",  {31'd0, err}, 32'd1);
    req(1'b1, 4'h0, 32'h0, 32'h0); tick();
    check("rd0_data", rdata, 32'h0BAD_F00D);
    check("rd0_err",  {31'd0, err}, 32'd0);

    // Back-to-back reads, then idle
    req(1'b1, 4'h0, 32'h10, 32'h0); tick();
    check("b2b_t1_data",  rdata, 32'h1234_5678);
    check("b2b_t1_valid", {31'd0, valid}, 32'd1);
    req(1'b1, 4'h0, 32'h20, 32'h0); tick();
    check("b2b_t2_data",  rdata, 32'h2233_11DD);
    check("b2b_t2_valid", {31'd0, valid}, 32'd1);
    req(1'b0, 4'h0, 32'h10, 32'h0); tick();
    check("idle_valid", {31'd0, valid}, 32'd0);
    check("idle_err",   {31'd0, err},   32'd0);
    check("idle_hold",  rdata, 32'h2233_11DD);

    // Read-after-write, byte offset ignored
    req(1'b1, 4'hF, 32'h40, 32'h5A5A_5A5A); tick();
    req(1'b1, 4'h0, 32'h43, 32'h0); tick();
    check("raw_data", rdata, 32'h5A5A_5A5A);
    check("raw_stall", {31'd0, stall}, 32'd0);
    req(1'b0, 4'h0, 32'h0, 32'h0); tick();

`ifdef DATA_SRAM_WAIT_EN
    // Two wait states: preload 0x10
    en2 = 1'b1; wen2 = 4'hF; addr2 = 32'h10; wdata2 = 32'h1234_5678; #1;
    check("w2_wr_stall_t0", {31'd0, stall2}, 32'd1);
    tick(); en2 = 1'b0;
    tick(); tick(); tick();
    // Read 0x10 with garbage presented during T+1
    en2 = 1'b1; wen2 = 4'h0; addr2 = 32'h10; wdata2 = 32'h0; #1;
    check("w2_stall_t0", {31'd0, stall2}, 32'd1);
    tick();
    wen2 = 4'hF; addr2 = 32'h10; wdata2 = 32'hFFFF_FFFF; #1;
    check("w2_stall_t1", {31'd0, stall2}, 32'd1);
    tick(); en2 = 1'b0;
    check("w2_stall_t2", {31'd0, stall2}, 32'd0);
    check("w2_valid_t2", {31'd0, valid2}, 32'd0);
    tick();
    check("w2_rdata_t3", rdata2, 32'h1234_5678);
    check("w2_valid_t3", {31'd0, valid2}, 32'd1);
    tick();
    check("w2_valid_t4", {31'd0, valid2}, 32'd0);

    // Three wait states: preload 0x30, then reset mid-wait on a new write
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h30; wdata3 = 32'hDEAD_BEEF;
    tick(); en3 = 1'b0;
    tick(); tick(); tick(); tick();
    en3 = 1'b1; wdata3 = 32'hCAFE_BABE;
    tick(); en3 = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    check("w3_rst_stall", {31'd0, stall3}, 32'd0);
    check("w3_rst_valid", {31'd0, valid3}, 32'd0);
    tick(); tick(); tick();
    check("w3_rst_noresp", {31'd0, valid3 | err3}, 32'd0);
    en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h30;
    tick(); en3 = 1'b0;
    tick(); tick(); tick();
    check("w3_rd_data",  rdata3, 32'hDEAD_BEEF);
    check("w3_rd_valid", {31'd0, valid3}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
